light_monitor: RTL and testbench
================================

LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameter RED_T, default 30, legal red phase length in clk cycles (1..254).
REQ-002 Parameter GRN_T, default 25, legal green phase length in clk cycles (1..254).
REQ-003 Parameter YEL_T, default 5, legal yellow phase length in clk cycles (1..254).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 r, g, y  input  1 each  observed lamp drives, synchronous to clk, no internal synchronizer.
REQ-007 phase  output  2  registered decoded phase: 00 unsync, 01 red, 10 green, 11 yellow.
REQ-008 err_code  output  1  one-cycle pulse: sampled {r,g,y} not one-hot.
REQ-009 err_seq  output  1  one-cycle pulse: legal color change out of order.
REQ-010 err_dur  output  1  one-cycle pulse: phase too short or too long.
REQ-011 cycle_done  output  1  one-cycle pulse: complete clean R-G-Y cycle observed.
REQ-012 err_cnt  output  8  saturating error counter (see Configuration).

Function
REQ-013 Inputs sampled every rising edge; all outputs registered; flags high for exactly the cycle after the edge at which the condition is sampled.
REQ-014 States: UNSYNC, RED, GRN, YEL; legal order RED->GRN->YEL->RED.
REQ-015 Internal cnt (8 bits, saturating at 255) = consecutive sampled cycles in current phase, including current; cnt <= 1 on every phase entry.
REQ-016 UNSYNC: holds last sampled code; when a one-hot code differing from last code is sampled, enter matching phase, cnt <= 1, no seq/dur check.
REQ-017 In a phase, same code sampled: cnt increments; if cnt equals phase's expected length before increment, err_dur pulses (once per phase; no further err_dur in that phase).
REQ-018 In a phase, different one-hot code sampled, legal successor: err_dur pulses if cnt < expected length; enter successor, cnt <= 1.
REQ-019 In a phase, different one-hot code sampled, not successor: err_seq pulses, no dur check, enter sampled color's phase, cnt <= 1.
REQ-020 Non-one-hot code sampled (000, 011, 101, 110, 111) in any state: err_code pulses, state <= UNSYNC, last code <= sampled code; repeats every cycle it persists.
REQ-021 Clean flag: set on every RED entry; cleared by any err_* pulse.
REQ-022 cycle_done pulses on a YEL->RED transition with cnt == YEL_T and clean flag set (evaluated before the RED-entry set).
REQ-023 phase output reflects the state after the sampling edge (1-cycle latency from input change).

Reset
REQ-024 rst asserted: state UNSYNC, phase 00, cnt 0, last code 000, clean 0, all pulse outputs 0, err_cnt 0, immediately and regardless of clk.
REQ-025 Reset mid-phase discards measurement; first post-reset phase is never duration-checked.

Configuration
REQ-026 Macro LIGHT_MON_ERRCNT_EN defined: err_cnt increments by 1 on each cycle where any of err_code/err_seq/err_dur is high (multiple simultaneous flags count once), saturating at 255.
REQ-027 Macro not defined: err_cnt tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-028 Reset, then R30 G25 Y5 R30 G25 Y5 from a legal light source -> phase tracks 01/10/11 after first change, cycle_done on second Y->R only, no error flags.
REQ-029 R held 30 then G held 24 then Y -> err_dur one cycle after first Y sample; no cycle_done at following Y->R.
REQ-030 G held 30 -> single err_dur one cycle after 26th G sample; no second pulse at G->Y.
REQ-031 From RED, drive Y directly -> err_seq pulse, phase 11, no err_dur; drive {r,g,y}=110 one cycle -> err_code, phase 00.
REQ-032 With LIGHT_MON_ERRCNT_EN, 300 cycles of code 111 -> err_cnt saturates at 255; without macro err_cnt stays 0.
REQ-033 Assert rst asynchronously mid-green (between edges) -> outputs cleared before next edge; resume yields no err_dur for the first post-reset phase.

Source files
------------

// File: rtl/light_monitor.sv
// +--------------------------------------------------------------------------+
// | light_monitor                                                             |
// | Checks a traffic light's R-G-Y sequence and phase lengths and flags        |
// | faults. Define LIGHT_MON_ERRCNT_EN to build the saturating err_cnt.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module light_monitor #(
  parameter int RED_T = 30,
  parameter int GRN_T = 25,
  parameter int YEL_T = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r,
  input  logic       g,
  input  logic       y,
  output logic [1:0] phase,
  output logic       err_code,
  output logic       err_seq,
  output logic       err_dur,
  output logic       cycle_done,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'b00,
    ST_RED    = 2'b01,
    ST_GRN    = 2'b10,
    ST_YEL    = 2'b11
  } state_t;

  localparam logic [7:0] C_RED_LEN = 8'(RED_T);
  localparam logic [7:0] C_GRN_LEN = 8'(GRN_T);
  localparam logic [7:0] C_YEL_LEN = 8'(YEL_T);

  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      ST_RED:  phase_len = C_RED_LEN;
      ST_GRN:  phase_len = C_GRN_LEN;
      ST_YEL:  phase_len = C_YEL_LEN;
      default: phase_len = 8'd0;
    endcase
  endfunction

  function automatic state_t successor(input state_t s);
    case (s)
      ST_RED:  successor = ST_GRN;
      ST_GRN:  successor = ST_YEL;
      ST_YEL:  successor = ST_RED;
      default: successor = ST_UNSYNC;
    endcase
  endfunction

  logic [2:0] code;
  logic       one_hot;
  state_t     code_st;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] last_q;
  logic       meas_q, meas_d;
  logic       clean_q, clean_d;
  logic       err_code_q, err_code_d;
  logic       err_seq_q, err_seq_d;
  logic       err_dur_q, err_dur_d;
  logic       done_q, done_d;
  logic       red_entry;

  assign code = {r, g, y};

  always_comb begin
    one_hot = 1'b1;
    code_st = ST_UNSYNC;
    case (code)
      3'b100:  code_st = ST_RED;
      3'b010:  code_st = ST_GRN;
      3'b001:  code_st = ST_YEL;
      default: one_hot = 1'b0;
    endcase
  end

  // meas_q marks a phase whose start was actually observed; phases entered
  // from UNSYNC began at an unknown time, so their length is never judged.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    meas_d     = meas_q;
    err_code_d = 1'b0;
    err_seq_d  = 1'b0;
    err_dur_d  = 1'b0;
    done_d     = 1'b0;
    red_entry  = 1'b0;
    if (!one_hot) begin
      err_code_d = 1'b1;
      state_d    = ST_UNSYNC;
      cnt_d      = 8'd0;
      meas_d     = 1'b0;
    end else if (state_q == ST_UNSYNC) begin
      if (code != last_q) begin
        state_d = code_st;
        cnt_d   = 8'd1;
        meas_d  = 1'b0;
      end
    end else if (code_st == state_q) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      if (meas_q && cnt_q == phase_len(state_q)) err_dur_d = 1'b1;
    end else begin
      if (code_st == successor(state_q)) begin
        if (meas_q && cnt_q < phase_len(state_q)) err_dur_d = 1'b1;
        if (state_q == ST_YEL && cnt_q == C_YEL_LEN && clean_q) done_d = 1'b1;
      end else begin
        err_seq_d = 1'b1;
      end
      red_entry = (code_st == ST_RED);
      state_d   = code_st;
      cnt_d     = 8'd1;
      meas_d    = 1'b1;
    end
  end

  // An error in the same cycle as a RED entry leaves the cycle unclean.
  always_comb begin
    clean_d = clean_q;
    if (err_code_d || err_seq_d || err_dur_d) clean_d = 1'b0;
    else if (red_entry)                       clean_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UNSYNC;
      cnt_q      <= 8'd0;
      last_q     <= 3'b000;
      meas_q     <= 1'b0;
      clean_q    <= 1'b0;
      err_code_q <= 1'b0;
      err_seq_q  <= 1'b0;
      err_dur_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= code;
      meas_q     <= meas_d;
      clean_q    <= clean_d;
      err_code_q <= err_code_d;
      err_seq_q  <= err_seq_d;
      err_dur_q  <= err_dur_d;
      done_q     <= done_d;
    end
  end

  assign phase      = state_q;
  assign err_code   = err_code_q;
  assign err_seq    = err_seq_q;
  assign err_dur    = err_dur_q;
  assign cycle_done = done_q;

`ifdef LIGHT_MON_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_code_d || err_seq_d || err_dur_d) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: directed scenarios followed by random light
// sequences, all compared cycle by cycle against a colour/run-length model.
`default_nettype none

module tb_light_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       r, g, y;
  logic [1:0] phase;
  logic       err_code, err_seq, err_dur, cycle_done;
  logic [7:0] err_cnt;

  light_monitor #(.RED_T(30), .GRN_T(25), .YEL_T(5)) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .y(y),
    .phase(phase), .err_code(err_code), .err_seq(err_seq),
    .err_dur(err_dur), .cycle_done(cycle_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: colour 0 none, 1 red, 2 green, 3 yellow.
  int         len[4] = '{0, 30, 25, 5};
  int         m_col, m_run, m_errs;
  bit         m_measured, m_ok_since_red;
  logic [2:0] m_last;
  bit         x_code, x_seq, x_dur, x_done;

  int n_done, n_dur, n_err;

  function automatic logic [2:0] code_of(input int col);
    case (col)
      1:       return 3'b100;
      2:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic model_reset();
    m_col = 0; m_run = 0; m_errs = 0; m_measured = 0; m_ok_since_red = 0;
    m_last = 3'b000; x_code = 0; x_seq = 0; x_dur = 0; x_done = 0;
  endtask

  task automatic model_step(input logic [2:0] c);
    int  col;
    bit  red_in;
    col = (c == 3'b100) ? 1 : (c == 3'b010) ? 2 : (c == 3'b001) ? 3 : 0;
    x_code = 0; x_seq = 0; x_dur = 0; x_done = 0; red_in = 0;
    if (col == 0) begin
      x_code = 1; m_col = 0; m_measured = 0;
    end else if (m_col == 0) begin
      if (c != m_last) begin m_col = col; m_run = 1; m_measured = 0; end
    end else if (col == m_col) begin
      if (m_measured && m_run == len[m_col]) x_dur = 1;
      m_run++;
    end else begin
      if (col == m_col % 3 + 1) begin
        if (m_measured && m_run < len[m_col]) x_dur = 1;
        if (m_col == 3 && m_run == len[3] && m_ok_since_red) x_done = 1;
      end else begin
        x_seq = 1;
      end
      red_in = (col == 1);
      m_col = col; m_run = 1; m_measured = 1;
    end
    if (x_code || x_seq || x_dur) begin
      m_ok_since_red = 0;
`ifdef LIGHT_MON_ERRCNT_EN
      if (m_errs < 255) m_errs++;
`endif
    end else if (red_in) begin
      m_ok_since_red = 1;
    end
    m_last = c;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase",      {6'd0, phase},      8'(m_col));
    chk("err_code",   {7'd0, err_code},   {7'd0, x_code});
    chk("err_seq",    {7'd0, err_seq},    {7'd0, x_seq});
    chk("err_dur",    {7'd0, err_dur},    {7'd0, x_dur});
    chk("cycle_done", {7'd0, cycle_done}, {7'd0, x_done});
    chk("err_cnt",    err_cnt,            8'(m_errs));
  endtask

  task automatic drive(input logic [2:0] c);
    @(negedge clk);
    {r, g, y} = c;
    @(posedge clk);
    model_step(c);
    #1;
    check_all();
    if (cycle_done) n_done++;
    if (err_dur) n_dur++;
    if (err_code || err_seq || err_dur) n_err++;
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) drive(c);
  endtask

  task automatic clear_counts();
    n_done = 0; n_dur = 0; n_err = 0;
  endtask

  logic [2:0] bad_codes[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    int cur, nxt, pick, lv;
    rst = 1'b1; {r, g, y} = 3'b000;
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Legal source: only the second Y->R completes a clean cycle.
    hold(3'b100, 30); hold(3'b010, 25); hold(3'b001, 5);
    hold(3'b100, 30); hold(3'b010, 25); hold(3'b001, 5);
    hold(3'b100, 1);
    chk("legal_done_count", 8'(n_done), 8'd1);
    chk("legal_err_count",  8'(n_err),  8'd0);

    // Short green, then no cycle_done.
    clear_counts();
    hold(3'b100, 29); hold(3'b010, 24); hold(3'b001, 5); hold(3'b100, 1);
    chk("short_green_dur",  8'(n_dur),  8'd1);
    chk("short_green_done", 8'(n_done), 8'd0);

    // Long green: a single err_dur.
    clear_counts();
    hold(3'b100, 29); hold(3'b010, 30); hold(3'b001, 5); hold(3'b100, 5);
    chk("long_green_dur", 8'(n_dur), 8'd1);

    // Out-of-order and bad code.
    hold(3'b001, 3);
    hold(3'b110, 1);
    hold(3'b100, 4);

    // Persistent illegal code.
    hold(3'b111, 300);
    hold(3'b100, 30);

    // Async reset mid-green, resumed green is not judged.
    hold(3'b010, 10);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
    clear_counts();
    hold(3'b010, 15); hold(3'b001, 5); hold(3'b100, 5);
    chk("post_reset_dur", 8'(n_dur), 8'd0);

    cur = 1;
    for (int s = 0; s < 60; s++) begin
      pick = $urandom_range(0, 99);
      if (pick < 8) begin
        hold(bad_codes[$urandom_range(0, 4)], $urandom_range(1, 3));
      end else begin
        nxt = (pick < 20) ? $urandom_range(1, 3) : cur % 3 + 1;
        lv  = (pick < 30) ? $urandom_range(1, 40) : len[nxt] + $urandom_range(0, 4) - 2;
        if (lv < 1) lv = 1;
        hold(code_of(nxt), lv);
        cur = nxt;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
